cache_axil_line_master: RTL

// Downstream of cache_core's line memory port. Turns each line request (refill or

---
 rtl/cache_axil_line_master_if.sv | 59 +++++
 rtl/cache_axil_line_master.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cache_axil_line_master_if.sv
// Line-request port plus AXI4-Lite master bus for cache_axil_line_master.
// master modport is the line master's view; slave is the memory/cache side.
interface cache_axil_line_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_BYTES = 16
);
  localparam int LW = LINE_BYTES * 8;
  localparam int SW = DATA_WIDTH / 8;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [LW-1:0]         mem_req_wline;
  logic                  mem_resp_valid;
  logic [LW-1:0]         mem_resp_rline;
  logic                  mem_resp_err;

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [SW-1:0]         wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  modport master (
    input  mem_req_valid, mem_req_we,
    input  mem_req_addr, mem_req_wline,
    output mem_req_ready, mem_resp_valid,
    output mem_resp_rline, mem_resp_err,
    output awvalid, awaddr, wvalid, wdata, wstrb,
    output bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    output mem_req_valid, mem_req_we,
    output mem_req_addr, mem_req_wline,
    input  mem_req_ready, mem_resp_valid,
    input  mem_resp_rline, mem_resp_err,
    input  awvalid, awaddr, wvalid, wdata, wstrb,
    input  bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/cache_axil_line_master.sv
// Splits one cache line request into single-word AXI4-Lite beats,
// one outstanding transaction at a time, and reassembles refills.
module cache_axil_line_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_BYTES = 16
) (
  input  logic clk,
  input  logic rst_n,
  cache_axil_line_master_if.master bus
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam int W   = LINE_BYTES / BPW;
  localparam int IW  = (W > 1) ? $clog2(W) : 1;
  localparam int LW  = LINE_BYTES * 8;
  localparam int SH  = $clog2(BPW);

  typedef enum logic [2:0] {
    IDLE, RD_AR, RD_R, WR_AW_W, WR_B, RESP
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LW-1:0]         wline_q;
  logic [LW-1:0]         rline_q;
  logic [IW-1:0]         idx_q;
  logic                  err_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  aw_done_q;
  logic                  w_done_q;

  logic                  last;
  logic                  aw_done_d;
  logic                  w_done_d;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  unused_ok;

  assign last      = (idx_q == IW'(W - 1));
  assign aw_done_d = aw_done_q | (awvalid_q & bus.awready);
  assign w_done_d  = w_done_q | (wvalid_q & bus.wready);
  assign beat_addr = base_q + (ADDR_WIDTH'(idx_q) << SH);
  assign unused_ok = ^{bus.rresp[0], bus.bresp[0]};

  assign bus.mem_req_ready  = req_ready_q;
  assign bus.mem_resp_valid = resp_valid_q;
  assign bus.mem_resp_rline = rline_q;
  assign bus.mem_resp_err   = err_q;
  assign bus.awvalid        = awvalid_q;
  assign bus.awaddr         = beat_addr;
  assign bus.wvalid         = wvalid_q;
  assign bus.wdata          = wline_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.wstrb          = '1;
  assign bus.bready         = bready_q;
  assign bus.arvalid        = arvalid_q;
  assign bus.araddr         = beat_addr;
  assign bus.rready         = rready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      wline_q      <= '0;
      rline_q      <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.mem_req_valid) begin
            base_q      <= bus.mem_req_addr
                         & ~ADDR_WIDTH'(LINE_BYTES - 1);
            wline_q     <= bus.mem_req_wline;
            rline_q     <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            if (bus.mem_req_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= WR_AW_W;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_AR;
            end
          end
        end
        RD_AR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_R;
          end
        end
        RD_R: begin
          if (bus.rvalid) begin
            rline_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] <= bus.rdata;
            err_q    <= err_q | bus.rresp[1];
            rready_q <= 1'b0;
            if (last) begin
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              idx_q     <= idx_q + 1'b1;
              arvalid_q <= 1'b1;
              state_q   <= RD_AR;
            end
          end
        end
        WR_AW_W: begin
          // address and data channels complete independently
          if (bus.awready) awvalid_q <= 1'b0;
          if (bus.wready)  wvalid_q  <= 1'b0;
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= WR_B;
          end
        end
        WR_B: begin
          if (bus.bvalid) begin
            bready_q <= 1'b0;
            err_q    <= err_q | bus.bresp[1];
            if (last) begin
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              idx_q     <= idx_q + 1'b1;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= WR_AW_W;
            end
          end
        end
        RESP: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
